// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master Wishbone classic arbiter placing the core's
// instruction port (iwb) and data port (dwb) onto one shared memory slave.
// One transfer per grant, round-robin on contention, and a programmable
// wait timeout that terminates a hung transfer with a bus error.
module wb_mem_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  // data master
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_we_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  // shared slave
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  // current owner, bit0 = iwb, bit1 = dwb
  output logic [1:0]  grant_o
);

  // A zero TIMEOUT_CYC disables the timeout; the counter then idles at 0.
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam int CW = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = TO_EN ? CW'(TIMEOUT_CYC) : {CW{1'b0}};

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic ireq_s, dreq_s, own_req_s, granted_s;
  logic to_hit_s, ack_s, err_s, bus_req_s, done_s;

  assign ireq_s    = iwb_cyc_i & iwb_stb_i;
  assign dreq_s    = dwb_cyc_i & dwb_stb_i;
  assign granted_s = (state_q != IDLE);

  // Request of whichever master currently owns the bus.
  always_comb begin
    own_req_s = 1'b0;
    case (state_q)
      GNT_I:   own_req_s = ireq_s;
      GNT_D:   own_req_s = dreq_s;
      default: own_req_s = 1'b0;
    endcase
  end

  // Timeout expiry; the slave ack still wins when it lands in the same cycle.
  assign to_hit_s  = TO_EN && granted_s && (cnt_q == TO_LIM);
  // Err from the slave suppresses a simultaneous ack.
  assign ack_s     = granted_s & m_ack_i & ~m_err_i;
  assign err_s     = granted_s & (m_err_i | (to_hit_s & ~m_ack_i & own_req_s));
  // Bus request is pulled down in the expiry cycle so the slave sees the cut.
  assign bus_req_s = own_req_s & ~to_hit_s;
  // Any termination, abort or expiry ends the grant.
  assign done_s    = m_ack_i | m_err_i | ~own_req_s | to_hit_s;

  // Read data is broadcast; only the owner's ack qualifies it.
  assign iwb_dat_o = m_dat_i;
  assign dwb_dat_o = m_dat_i;
  assign grant_o   = state_q;

  // Slave-side request muxing and termination steering to the owner only.
  always_comb begin
    m_adr_o   = 32'h0000_0000;
    m_dat_o   = 32'h0000_0000;
    m_sel_o   = 4'h0;
    m_we_o    = 1'b0;
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    case (state_q)
      GNT_I: begin
        m_adr_o   = iwb_adr_i;
        m_dat_o   = 32'h0000_0000;
        m_sel_o   = 4'hF;
        m_we_o    = 1'b0;
        m_cyc_o   = bus_req_s;
        m_stb_o   = bus_req_s;
        iwb_ack_o = ack_s;
        iwb_err_o = err_s;
      end
      GNT_D: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_sel_o   = dwb_sel_i;
        m_we_o    = dwb_we_i;
        m_cyc_o   = bus_req_s;
        m_stb_o   = bus_req_s;
        dwb_ack_o = ack_s;
        dwb_err_o = err_s;
      end
      default: begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
      end
    endcase
  end

  // Arbitration, one-transfer-per-grant sequencing and saturating wait count.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (ireq_s && (!dreq_s || last_d_q)) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
        end else if (dreq_s) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (done_s) begin
          state_d = IDLE;
        end else if (TO_EN && (cnt_q != TO_LIM)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers; last_d resets high so the first tie goes to iwb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed bench for wb_mem_arbiter with a registered-ack
// slave model and per-master scoreboards of expected read data.
module tb_wb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i, iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o, iwb_err_o;
  logic [31:0] dwb_adr_i, dwb_dat_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_we_i, dwb_cyc_i, dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o, dwb_err_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i, m_err_i;
  logic [1:0]  grant_o;

  wb_mem_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_sel_i(dwb_sel_i),
    .dwb_we_i(dwb_we_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .grant_o(grant_o)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the slave model.
  function automatic logic [31:0] slv_data(input logic [31:0] adr);
    return (adr == 32'h0000_0100) ? 32'h0000_0013 : (adr ^ 32'hC0DE_0000);
  endfunction

  // Registered-ack slave: acks one cycle after stb; err_mode also raises err.
  logic        slv_en, slv_err_mode, slv_ack_q;
  logic [31:0] slv_dat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slv_ack_q <= 1'b0;
      slv_dat_q <= 32'h0;
    end else begin
      slv_ack_q <= slv_en & m_cyc_o & m_stb_o & ~slv_ack_q;
      slv_dat_q <= slv_data(m_adr_o);
    end
  end
  assign m_ack_i = slv_ack_q;
  assign m_err_i = slv_ack_q & slv_err_mode;
  assign m_dat_i = slv_dat_q;

  int vec_n  = 0;
  int fail_n = 0;
  int n_iack = 0, n_ierr = 0, n_dack = 0, n_derr = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] i_adr, d_adr;
  bit i_auto, d_auto, i_done, d_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_i(input logic [31:0] adr);
    i_adr = adr; iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    exp_i.push_back(slv_data(adr));
  endtask

  task automatic drive_d(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input bit expect_term);
    d_adr = adr; dwb_adr_i = adr; dwb_dat_i = dat; dwb_sel_i = sel; dwb_we_i = we;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    if (expect_term) exp_d.push_back(slv_data(adr));
  endtask

  // Advance one cycle, then act as both masters and score terminations.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk); #1;
    if (i_done) begin
      i_done = 1'b0;
      if (i_auto) begin
        i_adr = i_adr + 32'd4; iwb_adr_i = i_adr; exp_i.push_back(slv_data(i_adr));
      end else begin
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      end
    end
    if (d_done) begin
      d_done = 1'b0;
      if (d_auto) begin
        d_adr = d_adr + 32'd4; dwb_adr_i = d_adr; exp_d.push_back(slv_data(d_adr));
      end else begin
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
      end
    end
    if (iwb_ack_o || iwb_err_o) begin
      chk("iwb_term_expected", {31'd0, exp_i.size() != 0}, 32'd1);
      if (exp_i.size() != 0) begin
        e = exp_i.pop_front();
        if (iwb_ack_o) chk("iwb_dat", iwb_dat_o, e);
      end
      if (iwb_ack_o) n_iack++; else n_ierr++;
      i_done = 1'b1;
    end
    if (dwb_ack_o || dwb_err_o) begin
      chk("dwb_term_expected", {31'd0, exp_d.size() != 0}, 32'd1);
      if (exp_d.size() != 0) begin
        e = exp_d.pop_front();
        if (dwb_ack_o) chk("dwb_dat", dwb_dat_o, e);
      end
      if (dwb_ack_o) n_dack++; else n_derr++;
      d_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; #2; rst = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
  endtask

  // Run until both masters are idle with nothing outstanding.
  task automatic drain(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (exp_i.size() == 0 && exp_d.size() == 0 && !i_done && !d_done &&
          !iwb_cyc_i && !dwb_cyc_i) begin
        idle = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int ia, da, g_cyc, e_cyc;
    logic [1:0] prev_g;
    logic [1:0] gseq[$];
    bit seen;

    rst = 1'b1;
    iwb_adr_i = 32'h0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    dwb_adr_i = 32'h0; dwb_dat_i = 32'h0; dwb_sel_i = 4'h0;
    dwb_we_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    slv_en = 1'b1; slv_err_mode = 1'b0;
    i_auto = 1'b0; d_auto = 1'b0; i_done = 1'b0; d_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    chk("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
    chk("rst_m_adr", m_adr_o, 32'd0);
    chk("rst_acks", {28'd0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 32'd0);
    rst = 1'b0;

    // Lone iwb read at 0x100.
    drive_i(32'h0000_0100);
    #1 chk("t1_grant_c0", {30'd0, grant_o}, 32'd0);
    tick();
    chk("t1_grant_c1", {30'd0, grant_o}, 32'd1);
    chk("t1_m_stb", {31'd0, m_stb_o}, 32'd1);
    chk("t1_m_adr", m_adr_o, 32'h0000_0100);
    chk("t1_m_we_sel", {27'd0, m_we_o, m_sel_o}, 32'h0000_000F);
    chk("t1_m_dat", m_dat_o, 32'd0);
    tick();
    chk("t1_grant_c2", {30'd0, grant_o}, 32'd1);
    chk("t1_iwb_ack", {31'd0, iwb_ack_o}, 32'd1);
    chk("t1_iwb_dat", iwb_dat_o, 32'h0000_0013);
    chk("t1_dwb_ack", {31'd0, dwb_ack_o}, 32'd0);
    tick();
    chk("t1_grant_c3", {30'd0, grant_o}, 32'd0);
    chk("t1_ack_once", {31'd0, iwb_ack_o}, 32'd0);
    chk("t1_n_iack", n_iack, 32'd1);

    // Lone dwb byte write.
    drive_d(32'h0000_1000, 32'h0000_0001, 4'b0001, 1'b1, 1'b1);
    tick();
    chk("t2_grant", {30'd0, grant_o}, 32'd2);
    chk("t2_m_we", {31'd0, m_we_o}, 32'd1);
    chk("t2_m_sel", {28'd0, m_sel_o}, 32'd1);
    chk("t2_m_dat", m_dat_o, 32'd1);
    chk("t2_m_adr", m_adr_o, 32'h0000_1000);
    drain("t2_drain");
    chk("t2_n_dack", n_dack, 32'd1);
    chk("t2_n_iack", n_iack, 32'd1);

    // Continuous contention from reset: strict alternation, 6 acks in 18 cycles.
    do_reset();
    ia = n_iack; da = n_dack;
    i_auto = 1'b1; d_auto = 1'b1;
    drive_i(32'h0000_2000);
    drive_d(32'h0000_3000, 32'h0, 4'hF, 1'b0, 1'b1);
    prev_g = 2'b00;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (grant_o != 2'b00 && prev_g == 2'b00) gseq.push_back(grant_o);
      prev_g = grant_o;
    end
    chk("t3_acks_18cyc", (n_iack - ia) + (n_dack - da), 32'd6);
    chk("t3_iacks", n_iack - ia, 32'd3);
    chk("t3_grants", gseq.size(), 32'd6);
    if (gseq.size() != 0) chk("t3_first_grant", {30'd0, gseq[0]}, 32'd1);
    for (int k = 1; k < gseq.size(); k++)
      chk("t3_alternate", {30'd0, gseq[k] ^ gseq[k-1]}, 32'd3);
    i_auto = 1'b0; d_auto = 1'b0;
    drain("t3_drain");

    // Timeout with a silent slave; pending dwb is granted afterwards.
    do_reset();
    slv_en = 1'b0;
    drive_i(32'h0000_0200);
    drive_d(32'h0000_0300, 32'h0, 4'hF, 1'b0, 1'b1);
    g_cyc = 0; e_cyc = -100;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (g_cyc == 0 && grant_o == 2'b01) g_cyc = k;
      if (iwb_err_o) begin
        e_cyc = k;
        chk("t4_stb_at_err", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
        chk("t4_no_ack_at_err", {31'd0, iwb_ack_o}, 32'd0);
        break;
      end
    end
    chk("t4_err_delay", e_cyc - g_cyc, 32'd16);
    tick();
    chk("t4_idle_after_err", {30'd0, grant_o}, 32'd0);
    chk("t4_err_one_cycle", {31'd0, iwb_err_o}, 32'd0);
    tick();
    chk("t4_dwb_next", {30'd0, grant_o}, 32'd2);
    slv_en = 1'b1;
    drain("t4_drain");
    chk("t4_n_ierr", n_ierr, 32'd1);

    // dwb aborts one cycle into its grant; pending iwb granted two cycles later.
    do_reset();
    slv_en = 1'b0;
    ia = n_iack;
    drive_d(32'h0000_0400, 32'h0, 4'hF, 1'b0, 1'b0);
    tick();
    chk("t5_grant_d", {30'd0, grant_o}, 32'd2);
    drive_i(32'h0000_0500);
    tick();
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    #1;
    chk("t5_cyc_falls", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
    chk("t5_no_term", {28'd0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 32'd0);
    tick();
    chk("t5_idle", {30'd0, grant_o}, 32'd0);
    tick();
    chk("t5_grant_i", {30'd0, grant_o}, 32'd1);
    slv_en = 1'b1;
    drain("t5_drain");
    chk("t5_iack", n_iack - ia, 32'd1);

    // Simultaneous slave ack and err: err reaches the master, ack does not.
    slv_err_mode = 1'b1;
    drive_d(32'h0000_0600, 32'h0, 4'hF, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dwb_ack_o || dwb_err_o) begin
        seen = 1'b1;
        chk("t6_err_wins", {30'd0, dwb_err_o, dwb_ack_o}, 32'd2);
        break;
      end
    end
    chk("t6_terminated", {31'd0, seen}, 32'd1);
    tick();
    slv_err_mode = 1'b0;
    drain("t6_drain");

    // Async reset during GNT_D, then the first tie goes to iwb.
    slv_en = 1'b0;
    drive_d(32'h0000_0700, 32'h0, 4'hF, 1'b0, 1'b0);
    tick();
    chk("t7_stb_before", {31'd0, m_stb_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_clear", {28'd0, m_cyc_o, m_stb_o, grant_o}, 32'd0);
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
    #1 rst = 1'b0;
    slv_en = 1'b1;
    drive_i(32'h0000_0800);
    drive_d(32'h0000_0900, 32'h0, 4'hF, 1'b0, 1'b1);
    tick();
    chk("t7_tie_to_iwb", {30'd0, grant_o}, 32'd1);
    drain("t7_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, fail_n);
    $finish;
  end

endmodule
